// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller signal bundle between the pipeline stages and pipe_hazard_ctrl.
// PIPE_STATS_EN adds the stall_cycles statistics signal.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic        id_is_md;
    logic [4:0]  ex_wa;
    logic        ex_is_load;
    logic        md_start;
    logic        md_is_div;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_stall;
    logic        flush;
    logic        md_busy;
    logic [3:0]  md_count;
    logic [4:0]  exc_code_q;
`ifdef PIPE_STATS_EN
    logic [15:0] stall_cycles;
`endif

    // master: the pipeline side that presents stage information and obeys the controls
    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, id_is_md,
        output ex_wa, ex_is_load, md_start, md_is_div, exc_req, exc_code,
        input  pc_en, if_id_en, id_ex_stall, flush, md_busy, md_count, exc_code_q
`ifdef PIPE_STATS_EN
        , input stall_cycles
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, id_is_md,
        input  ex_wa, ex_is_load, md_start, md_is_div, exc_req, exc_code,
        output pc_en, if_id_en, id_ex_stall, flush, md_busy, md_count, exc_code_q
`ifdef PIPE_STATS_EN
        , output stall_cycles
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use and HI/LO hazards,
// exception flush with ExcCode latch. Define PIPE_STATS_EN to add the stall_cycles counter.
module pipe_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic              clk,
    input logic              reset,
    pipe_hazard_ctrl_if.slave hz
);
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0] md_count_q;
    logic [4:0] exc_code_r;
    logic       md_busy;
    logic       load_use;
    logic       md_stall;
    logic       stall;
    logic       rs_hit;
    logic       rt_hit;

    assign md_busy = (md_count_q != 4'd0);

    always_comb begin
        rs_hit   = hz.id_rs_used && (hz.id_rs == hz.ex_wa);
        rt_hit   = hz.id_rt_used && (hz.id_rt == hz.ex_wa);
        load_use = hz.ex_is_load && (hz.ex_wa != 5'd0) && (rs_hit || rt_hit);
        // md_start counts as busy so an HI/LO reader right behind the mult/div waits
        md_stall = hz.id_is_md && (md_busy || hz.md_start);
        stall    = (load_use || md_stall) && !hz.exc_req;
    end

    // A start alongside an exception belongs to the killed EX instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            md_count_q <= 4'd0;
        end else if (hz.md_start && !hz.exc_req) begin
            md_count_q <= hz.md_is_div ? DIV_LOAD : MULT_LOAD;
        end else if (md_busy) begin
            md_count_q <= md_count_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_code_r <= 5'd0;
        end else if (hz.exc_req) begin
            exc_code_r <= hz.exc_code;
        end
    end

`ifdef PIPE_STATS_EN
    logic [15:0] stall_cycles_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= 16'd0;
        end else if (stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_q <= stall_cycles_q + 16'd1;
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
`endif

    assign hz.pc_en       = !stall;
    assign hz.if_id_en    = !stall;
    assign hz.id_ex_stall = stall;
    assign hz.flush       = hz.exc_req;
    assign hz.md_busy     = md_busy;
    assign hz.md_count    = md_count_q;
    assign hz.exc_code_q  = exc_code_r;
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It detects load-use hazards and HI/LO (multiply/divide) structural hazards, and drives the PC enable, the IF/ID enable and the ID/EX bubble insert. On an exception signalled from MEM it flushes the pipeline and latches the exception code. It owns the multiply/divide busy counter that the ID stage consults.

## Interface

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start (1..15)
- DIV_CYCLES, 10, busy cycles after a div/divu start (1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_rs_used  in  1  ID instruction reads rs in ID/EX
- id_rt_used  in  1  ID instruction reads rt in ID/EX
- id_is_md  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
- ex_wa  in  5  destination register of instruction in EX
- ex_is_load  in  1  EX instruction is a load
- md_start  in  1  EX issues a mult/div this cycle (single-cycle pulse)
- md_is_div  in  1  qualifies md_start: 1 = divide, 0 = multiply
- exc_req  in  1  MEM-stage instruction raises an exception
- exc_code  in  5  ExcCode accompanying exc_req
- pc_en  out  1  PC register write enable
- if_id_en  out  1  IF/ID register enable
- id_ex_stall  out  1  insert bubble into ID/EX (PC/BD still pass)
- flush  out  1  clear IF/ID, ID/EX and EX/MEM this edge
- md_busy  out  1  HI/LO unit busy
- md_count  out  4  remaining busy cycles
- exc_code_q  out  5  last latched ExcCode
- stall_cycles  out  16  only with PIPE_STATS_EN; otherwise absent

## Operation

- load_use = ex_is_load & (ex_wa != 0) & ((id_rs_used & id_rs == ex_wa) | (id_rt_used & id_rt == ex_wa)).
- md_stall = id_is_md & (md_busy | md_start).
- stall = (load_use | md_stall) & ~exc_req.
- Outputs: pc_en = if_id_en = ~stall; id_ex_stall = stall; flush = exc_req. All are combinational.
- md counter:
  - On a clock edge with md_start & ~exc_req, it loads DIV_CYCLES if md_is_div, else MULT_CYCLES. This reload applies even if the counter is nonzero.
  - Otherwise it decrements when nonzero and holds at 0.
  - md_busy = (md_count != 0).
- Exception:
  - md_start in the same cycle as exc_req is ignored, because the EX instruction is younger and is killed.
  - An operation already in flight keeps counting.
  - exc_code_q loads exc_code on each edge where exc_req is high. Otherwise it holds.
- Priority: exc_req > md_stall, and exc_req > load_use. Under flush: pc_en=1, if_id_en=1, id_ex_stall=0.

## Timing

- Reset state: md_count=0, md_busy=0, exc_code_q=0, stall_cycles=0. reset overrides md_start and exc_req on the same edge.
- Combinational outputs follow the inputs and the cleared state during and after reset. With all inputs at 0: pc_en=1, if_id_en=1, id_ex_stall=0, flush=0.
- Multiply timing, md_start at cycle t with MULT_CYCLES=5:
  - md_count reads 5,4,3,2,1 in cycles t+1..t+5, and 0 at t+6.
  - md_busy is high for cycles t+1..t+5.
  - An mflo held in ID stalls in cycles t..t+5 and advances at t+6.
- Load-use stall lasts exactly one cycle for a single dependent instruction, because the load leaves EX.
- Stall and exception signals have zero-cycle latency. Registered state has one-cycle latency.
- A reset asserted mid-operation clears md_count immediately at that edge.

## Configuration

- PIPE_STATS_EN defined: adds stall_cycles, a 16-bit counter.
  - Increments on every edge where stall=1 and reset=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- PIPE_STATS_EN undefined: the port and the counter are not present. All other behaviour is identical.

## Test plan

- Load-use: ex_is_load=1, ex_wa=8, id_rs=8, id_rs_used=1 for one cycle -> pc_en=0, if_id_en=0, id_ex_stall=1 for that cycle only. With ex_wa=0 -> no stall.
- Divide: md_start=1, md_is_div=1 at t, with id_is_md=1 held -> md_count 10..1 over t+1..t+10, and stall high for t..t+10, deasserted at t+11.
- Exception during stall: load_use true plus exc_req=1, exc_code=5'h0C -> flush=1, id_ex_stall=0, pc_en=1; exc_code_q=0x0C next cycle.
- Killed start: md_start=1 with exc_req=1 -> md_count stays 0 and md_busy stays 0.
- Reset mid-divide: assert reset at count 6 -> md_count=0 and exc_code_q=0 after the edge; pc_en=1.
- PIPE_STATS_EN: 3 load-use stalls plus a 5-cycle mult stall on an mfhi in ID -> stall_cycles=9. Preload near 0xFFFF -> the counter saturates and holds.
